ddrlvds_rx_deframe: RTL and testbench
=====================================

# ddrlvds_rx_deframe

Receive-side deframer for the byte-wide DDR LVDS sample interface toward the DAC: consumes the already-captured rising/falling byte pairs and frame bits (IDDR outputs in the 2x radio clock domain), locks to the I/Q frame cadence, and reassembles 16-bit I/Q sample pairs. Detects the extended 3-word frame assertion used for multi-DAC sync and flags framing errors. Used on loopback/capture paths and in the FPGA-to-FPGA test harness for the DAC interface.

## Interface
- LOCK_PAIRS, 4: consecutive well-formed pairs required in HUNT before declaring lock (1..15).
- ERR_W, 16: width of the framing error counter.

- rx_clk_2x  in  1  2x radio clock; all logic on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- d_rise  in  8  byte captured on rising edge (word bits [15:8]).
- d_fall  in  8  byte captured on falling edge (word bits [7:0]).
- frame_rise  in  1  frame bit captured on rising edge.
- frame_fall  in  1  frame bit captured on falling edge.
- clear_err  in  1  synchronous clear of err_count.
- i  out  16  I sample of reassembled pair.
- q  out  16  Q sample of reassembled pair.
- valid  out  1  one-cycle strobe, i/q valid.
- locked  out  1  deframer locked to frame cadence.
- sync_detected  out  1  one-cycle pulse on recognised sync sequence.
- err_count  out  ERR_W  saturating count of framing errors.

## Operation
- Per cycle: word w = {d_rise, d_fall}, frame f = frame_rise. Word with f=1 is I, f=0 is Q. Normal stream: f = 1,0,1,0...
- Glitch error: frame_rise != frame_fall in any cycle.
- Internal: previous word/frame register (w_d, f_d); ones-run counter (saturates at 4); good-pair counter; state.
- Pair boundary: f_d=1 and f=0. Pair = {i=w_d, q=w}.
- Well-formed pair: pair boundary with ones-run of exactly 1 before the 0, no glitch.
- Sync sequence: ones-run of exactly 3 followed by f=0, no glitch. Middle pair of the sync is dropped by design; the final one-word + zero-word pair is valid data.
- Error conditions (while LOCKED): glitch; two consecutive f=0 words; ones-run of 2 or >=4 terminated by f=0; ones-run reaching 4.
- States:
  - HUNT: valid=0, locked=0. Well-formed pair -> good-pair counter +1; any other boundary or glitch -> counter cleared. Counter reaching LOCK_PAIRS -> LOCKED (the LOCK_PAIRS-th pair is not emitted). Sync sequence in HUNT -> counter cleared, no pulse, no error count.
  - LOCKED: locked=1. Well-formed pair -> emit. Sync sequence -> emit final pair, pulse sync_detected, stay LOCKED. Error condition -> err_count +1, -> HUNT, counter cleared, no emit.
- err_count saturates at all-ones; clear_err zeroes it, and wins over a simultaneous increment.
- Reset mid-operation: all state lost immediately; returns to HUNT.

## Timing
- Reset values: i=0, q=0, valid=0, locked=0, sync_detected=0, err_count=0, state HUNT, run/pair counters 0, f_d=0.
- Latency: Q word presented in cycle n -> i/q/valid registered in cycle n+1. sync_detected asserts in the same cycle as the valid of the sync's final pair.
- Locked steady state: valid high every second cycle; a sync sequence inserts one extra 2-cycle gap.
- locked rises in cycle n+1 after the boundary of the LOCK_PAIRS-th good pair; falls in cycle n+1 after the erroring word.
- i/q hold last value while valid=0.

## Configuration
- DDRLVDS_RX_ERR_CNT_EN defined: err_count counter and clear_err logic present as described.
- Not defined: err_count tied to 0, clear_err ignored; error detection, state transitions and locking unchanged.

## Test plan
- Reset, then stream f=1,0 alternating with words 0x1111,0x2222,0x3333,0x4444...: locked rises after 4th pair; first emitted pair i=0x9999,q=0xAAAA (5th); valid every 2nd cycle.
- Locked, inject f=1,1,1,0: sync_detected pulses with valid of final pair; i/q equal third-one and zero words; err_count unchanged; locked stays 1.
- Locked, inject f=0,0: err_count=1, locked drops next cycle, relock after 4 good pairs.
- Locked, frame_rise=1, frame_fall=0 once: glitch counted, HUNT; with macro undefined err_count stays 0 but locked still drops.
- Force err_count to saturation (ERR_W=4, 16 errors): holds 0xF; assert clear_err same cycle as error -> 0.
- Assert reset_n low mid-stream asynchronously: outputs zero without a clock edge; after release, HUNT and relock within 4 pairs.

Source files
------------

// File: rtl/ddrlvds_rx_deframe.sv
// DDR LVDS receive deframer: locks to the I/Q frame cadence and rebuilds 16-bit sample pairs.
// Framing error counter is present only when DDRLVDS_RX_ERR_CNT_EN is defined.
module ddrlvds_rx_deframe #(
    parameter int LOCK_PAIRS = 4,
    parameter int ERR_W      = 16
) (
    input  logic             rx_clk_2x,
    input  logic             reset_n,
    input  logic [7:0]       d_rise,
    input  logic [7:0]       d_fall,
    input  logic             frame_rise,
    input  logic             frame_fall,
    input  logic             clear_err,
    output logic [15:0]      i,
    output logic [15:0]      q,
    output logic             valid,
    output logic             locked,
    output logic             sync_detected,
    output logic [ERR_W-1:0] err_count
);
    // state   | meaning
    // S_HUNT  | counting consecutive well-formed pairs, nothing emitted
    // S_LOCKED| emitting pairs, any framing error drops back to S_HUNT
    typedef enum logic {S_HUNT, S_LOCKED} state_t;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_w_d;
    logic        r_f_d;
    logic [2:0]  r_run;
    logic [3:0]  r_good, w_good_nxt;
    logic [15:0] r_i, r_q;
    logic        r_valid, r_sync;

    logic [15:0] w_word;
    logic        w_f, w_glitch, w_boundary, w_good_pair, w_sync, w_err_cond;
    logic        w_emit, w_sync_pulse, w_err_inc;
    logic [2:0]  w_run_nxt;

    assign w_word      = {d_rise, d_fall};
    assign w_f         = frame_rise;
    assign w_glitch    = frame_rise ^ frame_fall;
    assign w_boundary  = r_f_d & ~w_f;
    assign w_good_pair = w_boundary & (r_run == 3'd1) & ~w_glitch;
    assign w_sync      = w_boundary & (r_run == 3'd3) & ~w_glitch;
    // A run of three ones is only legal if it ends now; a fourth one is already an error.
    assign w_err_cond  = w_glitch
                       | (~r_f_d & ~w_f)
                       | (w_boundary & ((r_run == 3'd2) | (r_run >= 3'd4)))
                       | (w_f & (r_run >= 3'd3));
    assign w_run_nxt   = w_f ? ((r_run >= 3'd4) ? 3'd4 : r_run + 3'd1) : 3'd0;

    always_comb begin
        w_state_nxt  = r_state;
        w_good_nxt   = r_good;
        w_emit       = 1'b0;
        w_sync_pulse = 1'b0;
        w_err_inc    = 1'b0;
        case (r_state)
            S_HUNT: begin
                if (w_good_pair) begin
                    if (r_good == 4'(LOCK_PAIRS - 1)) begin
                        w_state_nxt = S_LOCKED;
                        w_good_nxt  = 4'd0;
                    end else begin
                        w_good_nxt = r_good + 4'd1;
                    end
                end else if (w_boundary | w_glitch) begin
                    w_good_nxt = 4'd0;
                end
            end
            S_LOCKED: begin
                if (w_err_cond) begin
                    w_err_inc   = 1'b1;
                    w_state_nxt = S_HUNT;
                    w_good_nxt  = 4'd0;
                end else if (w_good_pair) begin
                    w_emit = 1'b1;
                end else if (w_sync) begin
                    w_emit       = 1'b1;
                    w_sync_pulse = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_HUNT;
                w_good_nxt  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge rx_clk_2x or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_HUNT;
            r_w_d   <= 16'd0;
            r_f_d   <= 1'b0;
            r_run   <= 3'd0;
            r_good  <= 4'd0;
            r_i     <= 16'd0;
            r_q     <= 16'd0;
            r_valid <= 1'b0;
            r_sync  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_w_d   <= w_word;
            r_f_d   <= w_f;
            r_run   <= w_run_nxt;
            r_good  <= w_good_nxt;
            r_valid <= w_emit;
            r_sync  <= w_sync_pulse;
            if (w_emit) begin
                r_i <= r_w_d;
                r_q <= w_word;
            end
        end
    end

`ifdef DDRLVDS_RX_ERR_CNT_EN
    logic [ERR_W-1:0] r_err_cnt;

    // Clear has priority over an increment in the same cycle.
    always_ff @(posedge rx_clk_2x or negedge reset_n) begin
        if (!reset_n) begin
            r_err_cnt <= '0;
        end else if (clear_err) begin
            r_err_cnt <= '0;
        end else if (w_err_inc && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + ERR_W'(1);
        end
    end

    assign err_count = r_err_cnt;
`else
    logic w_unused;
    assign w_unused  = clear_err ^ w_err_inc;
    assign err_count = '0;
`endif

    assign i             = r_i;
    assign q             = r_q;
    assign valid         = r_valid;
    assign sync_detected = r_sync;
    assign locked        = (r_state == S_LOCKED);

endmodule

// File: tb/tb_ddrlvds_rx_deframe.sv
// Directed bench for ddrlvds_rx_deframe: lock, emit, sync, errors, saturation, async reset.
module tb_ddrlvds_rx_deframe;
    logic        rx_clk_2x = 1'b0;
    logic        reset_n;
    logic [7:0]  d_rise, d_fall;
    logic        frame_rise, frame_fall, clear_err;
    logic [15:0] i, q;
    logic        valid, locked, sync_detected;
    logic [3:0]  err_count;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [3:0]  exp_err = 4'd0;

`ifdef DDRLVDS_RX_ERR_CNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    ddrlvds_rx_deframe #(.LOCK_PAIRS(4), .ERR_W(4)) dut (
        .rx_clk_2x     (rx_clk_2x),
        .reset_n       (reset_n),
        .d_rise        (d_rise),
        .d_fall        (d_fall),
        .frame_rise    (frame_rise),
        .frame_fall    (frame_fall),
        .clear_err     (clear_err),
        .i             (i),
        .q             (q),
        .valid         (valid),
        .locked        (locked),
        .sync_detected (sync_detected),
        .err_count     (err_count)
    );

    always #5 rx_clk_2x = ~rx_clk_2x;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    endtask

    task automatic send(input logic [15:0] w, input logic fr, input logic ff);
        d_rise     = w[15:8];
        d_fall     = w[7:0];
        frame_rise = fr;
        frame_fall = ff;
        @(posedge rx_clk_2x);
        #1;
    endtask

    task automatic pair(input logic [15:0] wi, input logic [15:0] wq);
        send(wi, 1'b1, 1'b1);
        send(wq, 1'b0, 1'b0);
    endtask

    task automatic note_err();
        if (ERR_EN && exp_err != 4'hF) exp_err = exp_err + 4'd1;
    endtask

    // Four good pairs from HUNT: still unlocked after the 3rd, locked after the 4th.
    task automatic relock(input logic [15:0] base);
        for (int j = 0; j < 4; j++) begin
            pair(base + 16'(2 * j), base + 16'(2 * j + 1));
            chk("relock_locked", locked, (j == 3) ? 1 : 0);
        end
    endtask

    initial begin
        reset_n = 1'b0; d_rise = 8'd0; d_fall = 8'd0;
        frame_rise = 1'b0; frame_fall = 1'b0; clear_err = 1'b0;
        #12;
        chk("rst_i", i, 0);
        chk("rst_q", q, 0);
        chk("rst_valid", valid, 0);
        chk("rst_locked", locked, 0);
        chk("rst_sync", sync_detected, 0);
        chk("rst_err", err_count, 0);
        #5 reset_n = 1'b1;
        @(posedge rx_clk_2x);
        #1;

        for (int k = 1; k <= 4; k++) begin
            pair(16'(16'h1111 * (2 * k - 1)), 16'(16'h1111 * (2 * k)));
            chk("lock_locked", locked, (k == 4) ? 1 : 0);
            chk("lock_valid", valid, 0);
        end
        send(16'h9999, 1'b1, 1'b1);
        chk("p5_i_valid", valid, 0);
        chk("p5_i_hold", i, 16'h0000);
        send(16'hAAAA, 1'b0, 1'b0);
        chk("p5_valid", valid, 1);
        chk("p5_i", i, 16'h9999);
        chk("p5_q", q, 16'hAAAA);
        send(16'hBBBB, 1'b1, 1'b1);
        chk("p6_gap_valid", valid, 0);
        chk("p6_gap_i_hold", i, 16'h9999);
        send(16'hCCCC, 1'b0, 1'b0);
        chk("p6_valid", valid, 1);
        chk("p6_q", q, 16'hCCCC);

        send(16'h0A01, 1'b1, 1'b1);
        chk("sync1_valid", valid, 0);
        send(16'h0A02, 1'b1, 1'b1);
        chk("sync2_valid", valid, 0);
        chk("sync2_pulse", sync_detected, 0);
        send(16'h0A03, 1'b1, 1'b1);
        chk("sync3_valid", valid, 0);
        send(16'h0A04, 1'b0, 1'b0);
        chk("sync_pulse", sync_detected, 1);
        chk("sync_valid", valid, 1);
        chk("sync_i", i, 16'h0A03);
        chk("sync_q", q, 16'h0A04);
        chk("sync_locked", locked, 1);
        chk("sync_err", err_count, exp_err);
        pair(16'h0B01, 16'h0B02);
        chk("post_sync_pulse", sync_detected, 0);
        chk("post_sync_valid", valid, 1);
        chk("post_sync_i", i, 16'h0B01);

        send(16'h0C00, 1'b0, 1'b0);
        note_err();
        chk("zz_locked", locked, 0);
        chk("zz_valid", valid, 0);
        chk("zz_err", err_count, exp_err);
        relock(16'h2000);

        send(16'h0D01, 1'b1, 1'b0);
        note_err();
        chk("glitch_locked", locked, 0);
        chk("glitch_err", err_count, exp_err);
        send(16'h0D02, 1'b0, 1'b0);
        chk("glitch_q_valid", valid, 0);
        pair(16'h3001, 16'h3002);
        pair(16'h3003, 16'h3004);
        pair(16'h3005, 16'h3006);
        chk("glitch_relock", locked, 1);
        pair(16'h3007, 16'h3008);
        chk("glitch_emit_valid", valid, 1);
        chk("glitch_emit_i", i, 16'h3007);
        chk("glitch_emit_q", q, 16'h3008);

        for (int n = 0; n < 14; n++) begin
            send(16'h0E00, 1'b0, 1'b0);
            note_err();
            chk("sat_err", err_count, exp_err);
            relock(16'h4000);
        end
        chk("sat_full", err_count, ERR_EN ? 4'hF : 4'h0);
        send(16'h0E00, 1'b0, 1'b0);
        note_err();
        chk("sat_hold", err_count, exp_err);
        relock(16'h4100);
        clear_err = 1'b1;
        send(16'h0E00, 1'b0, 1'b0);
        clear_err = 1'b0;
        exp_err = 4'd0;
        chk("clr_vs_inc_err", err_count, exp_err);
        chk("clr_vs_inc_locked", locked, 0);

        relock(16'h5000);
        pair(16'h5101, 16'h5102);
        chk("pre_rst_i", i, 16'h5101);
        #3 reset_n = 1'b0;
        #1;
        chk("arst_i", i, 0);
        chk("arst_q", q, 0);
        chk("arst_valid", valid, 0);
        chk("arst_locked", locked, 0);
        chk("arst_sync", sync_detected, 0);
        chk("arst_err", err_count, 0);
        d_rise = 8'd0; d_fall = 8'd0; frame_rise = 1'b0; frame_fall = 1'b0;
        #2 reset_n = 1'b1;
        @(posedge rx_clk_2x);
        #1;
        relock(16'h6000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
